// File: rtl/fp_mant_normalizer_if.sv
// Handshake bundle between the mantissa adder and the post-add normalizer.
// The slave modport is the normalizer's view; the master modport is the producer/consumer side.
interface fp_mant_normalizer_if #(
    parameter int MW = 24,
    parameter int EW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_mant;
    logic          in_carry;
    logic [EW-1:0] in_exp;
    logic          in_sign;

    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_mant;
    logic [EW-1:0] out_exp;
    logic          out_sign;
    logic          out_zero;
    logic          out_sticky;
    logic          out_underflow;
    logic          out_overflow;

    modport master (
        output in_valid, in_mant, in_carry, in_exp, in_sign, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_sign,
               out_zero, out_sticky, out_underflow, out_overflow
    );

    modport slave (
        input  in_valid, in_mant, in_carry, in_exp, in_sign, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_sign,
               out_zero, out_sticky, out_underflow, out_overflow
    );
endinterface

// File: rtl/fp_mant_normalizer.sv
// Sequential post-adder normalizer: carry right-shift, zero detect, and a
// one-bit-per-cycle left shift until the hidden bit is set or the exponent bottoms out.
module fp_mant_normalizer #(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fp_mant_normalizer_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [EW-1:0] EXP_MAX = '1;
    localparam logic [EW-1:0] EXP_ONE = EW'(1);

    state_t        r_state, w_state_nxt;
    logic [MW-1:0] r_mant, w_mant_nxt;
    logic [EW-1:0] r_exp, w_exp_nxt;
    logic          r_sign, w_sign_nxt;
    logic          r_zero, w_zero_nxt;
    logic          r_sticky, w_sticky_nxt;
    logic          r_underflow, w_underflow_nxt;
    logic          r_overflow, w_overflow_nxt;

    logic [EW-1:0] w_exp_inc;
    logic          w_inc_ovf;
    logic [MW-1:0] w_mant_shl;

    assign w_exp_inc  = bus.in_exp + EXP_ONE;
    // Saturate at all-ones; also catches in_exp == EXP_MAX so the increment can never wrap.
    assign w_inc_ovf  = (bus.in_exp >= (EXP_MAX - EXP_ONE));
    assign w_mant_shl = {r_mant[MW-2:0], 1'b0};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_mant_nxt      = r_mant;
        w_exp_nxt       = r_exp;
        w_sign_nxt      = r_sign;
        w_zero_nxt      = r_zero;
        w_sticky_nxt    = r_sticky;
        w_underflow_nxt = r_underflow;
        w_overflow_nxt  = r_overflow;

        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_sign_nxt      = bus.in_sign;
                    w_zero_nxt      = 1'b0;
                    w_sticky_nxt    = 1'b0;
                    w_underflow_nxt = 1'b0;
                    w_overflow_nxt  = 1'b0;
                    if (bus.in_carry) begin
                        w_mant_nxt   = {1'b1, bus.in_mant[MW-1:1]};
                        w_sticky_nxt = bus.in_mant[0];
                        w_exp_nxt    = w_exp_inc;
                        if (w_inc_ovf) begin
                            w_mant_nxt     = '0;
                            w_exp_nxt      = EXP_MAX;
                            w_overflow_nxt = 1'b1;
                        end
                        w_state_nxt = DONE;
                    end else if (bus.in_mant == '0) begin
                        w_mant_nxt  = '0;
                        w_exp_nxt   = '0;
                        w_sign_nxt  = 1'b0;
                        w_zero_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_mant_nxt  = bus.in_mant;
                        w_exp_nxt   = bus.in_exp;
                        // Already normalized, or a denormal that must not be shifted.
                        w_state_nxt = (bus.in_mant[MW-1] || bus.in_exp == '0) ? DONE : SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (r_mant[MW-1]) begin
                    w_state_nxt = DONE;
                end else if (r_exp > EXP_ONE) begin
                    w_mant_nxt = w_mant_shl;
                    w_exp_nxt  = r_exp - EXP_ONE;
                    // MSB detection folded into the last shift saves a cycle.
                    if (w_mant_shl[MW-1]) w_state_nxt = DONE;
                end else begin
                    w_exp_nxt       = '0;
                    w_underflow_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) w_state_nxt = IDLE;
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mant      <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_sticky    <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mant      <= w_mant_nxt;
            r_exp       <= w_exp_nxt;
            r_sign      <= w_sign_nxt;
            r_zero      <= w_zero_nxt;
            r_sticky    <= w_sticky_nxt;
            r_underflow <= w_underflow_nxt;
            r_overflow  <= w_overflow_nxt;
        end
    end

    assign bus.in_ready      = (r_state == IDLE);
    assign bus.out_valid     = (r_state == DONE);
    assign bus.out_mant      = r_mant;
    assign bus.out_exp       = r_exp;
    assign bus.out_sign      = r_sign;
    assign bus.out_zero      = r_zero;
    assign bus.out_sticky    = r_sticky;
    assign bus.out_underflow = r_underflow;
    assign bus.out_overflow  = r_overflow;
endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Directed, table-driven bench for fp_mant_normalizer, plus hand-written
// back-pressure and mid-shift reset sequences.
module tb_fp_mant_normalizer;
    localparam int MW = 24;
    localparam int EW = 8;

    typedef struct {
        logic          carry;
        logic [MW-1:0] mant;
        logic [EW-1:0] exp_in;
        logic          sign;
        logic [MW-1:0] o_mant;
        logic [EW-1:0] o_exp;
        logic          o_sign;
        logic          o_zero;
        logic          o_sticky;
        logic          o_uf;
        logic          o_of;
        int            lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    vec_t vecs[11];

    fp_mant_normalizer_if #(.MW(MW), .EW(EW)) bus ();

    fp_mant_normalizer #(.MW(MW), .EW(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.in_carry = v.carry;
        bus.in_mant  = v.mant;
        bus.in_exp   = v.exp_in;
        bus.in_sign  = v.sign;
    endtask

    // Captures one vector, measures latency, checks the result, then drains it.
    task automatic run_vec(input int idx, input vec_t v);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d latency", idx), lat, v.lat);
        check($sformatf("v%0d in_ready low while busy", idx), busy_ok, 1'b1);
        check($sformatf("v%0d in_ready in DONE", idx), bus.in_ready, 1'b0);
        check($sformatf("v%0d out_mant", idx), bus.out_mant, v.o_mant);
        check($sformatf("v%0d out_exp", idx), bus.out_exp, v.o_exp);
        check($sformatf("v%0d out_sign", idx), bus.out_sign, v.o_sign);
        check($sformatf("v%0d out_zero", idx), bus.out_zero, v.o_zero);
        check($sformatf("v%0d out_sticky", idx), bus.out_sticky, v.o_sticky);
        check($sformatf("v%0d out_underflow", idx), bus.out_underflow, v.o_uf);
        check($sformatf("v%0d out_overflow", idx), bus.out_overflow, v.o_of);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check($sformatf("v%0d out_valid after accept", idx), bus.out_valid, 1'b0);
        check($sformatf("v%0d in_ready after accept", idx), bus.in_ready, 1'b1);
    endtask

    initial begin
        vec_t          v;
        logic [MW-1:0] held_mant;
        logic [EW-1:0] held_exp;
        int            waited;

        n_tests = 0;
        n_fail  = 0;
        //            carry mant       exp   sg  o_mant     o_exp sg z  st uf of lat
        vecs[0]  = '{1'b1, 24'h000000, 8'd127, 1'b0, 24'h800000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{1'b0, 24'h000001, 8'd127, 1'b0, 24'h800000, 8'd104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24};
        vecs[2]  = '{1'b0, 24'h000000, 8'd90,  1'b1, 24'h000000, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{1'b0, 24'h000100, 8'd5,   1'b0, 24'h001000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6};
        vecs[4]  = '{1'b1, 24'h000003, 8'd254, 1'b0, 24'h000000, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[5]  = '{1'b1, 24'h000003, 8'd100, 1'b1, 24'h800001, 8'd101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{1'b0, 24'hC00000, 8'd50,  1'b1, 24'hC00000, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{1'b0, 24'h400000, 8'd0,   1'b0, 24'h400000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b0, 24'h400000, 8'd1,   1'b1, 24'h400000, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[9]  = '{1'b0, 24'h000F00, 8'd20,  1'b0, 24'hF00000, 8'd8,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13};
        vecs[10] = '{1'b1, 24'hFFFFFF, 8'd253, 1'b0, 24'hFFFFFF, 8'd254, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};

        bus.in_valid  = 1'b0;
        bus.in_carry  = 1'b0;
        bus.in_mant   = '0;
        bus.in_exp    = '0;
        bus.in_sign   = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset in_ready", bus.in_ready, 1'b1);
        check("reset out_mant", bus.out_mant, '0);
        check("reset out_exp", bus.out_exp, '0);
        check("reset flags", {bus.out_sign, bus.out_zero, bus.out_sticky,
                              bus.out_underflow, bus.out_overflow}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Back-pressure: result held for 5 cycles while in_valid toggles with other data.
        @(negedge clk);
        drive(vecs[5]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_mant  = 24'h123456;
        bus.in_exp   = 8'd7;
        check("bp out_valid", bus.out_valid, 1'b1);
        held_mant = bus.out_mant;
        held_exp  = bus.out_exp;
        check("bp captured mant", held_mant, 24'h800001);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            @(posedge clk);
            #1;
            check($sformatf("bp c%0d out_valid", c), bus.out_valid, 1'b1);
            check($sformatf("bp c%0d out_mant", c), bus.out_mant, held_mant);
            check($sformatf("bp c%0d out_exp", c), bus.out_exp, held_exp);
            check($sformatf("bp c%0d in_ready", c), bus.in_ready, 1'b0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp released out_valid", bus.out_valid, 1'b0);
        check("bp released in_ready", bus.in_ready, 1'b1);

        // Asynchronous reset in the middle of a long shift sequence.
        @(negedge clk);
        drive(vecs[1]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        waited = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("mid-shift in_ready", bus.in_ready, 1'b0);
        check("mid-shift out_valid", bus.out_valid, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", bus.out_valid, 1'b0);
        check("async rst in_ready", bus.in_ready, 1'b1);
        check("async rst out_mant", bus.out_mant, '0);
        check("async rst out_exp", bus.out_exp, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post-rst no stale result", bus.out_valid, 1'b0);
        run_vec(100, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
